// File: rtl/bin2bcd_seq_pkg.sv
// rtl/bin2bcd_seq_pkg.sv - shared BCD constants and FSM state encodings for bin2bcd_seq
package bin2bcd_seq_pkg;

  localparam int BCD_DIG_W   = 4;
  localparam int BCD_ADJ_TH  = 5;
  localparam int BCD_ADJ_ADD = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - one BCD digit add-3 cell (5..9 -> 8..12), purely combinational
module bcd_digit_adj
  import bin2bcd_seq_pkg::*;
(
  input  logic [BCD_DIG_W-1:0] din,
  output logic [BCD_DIG_W-1:0] dout
);

  assign dout = (din >= BCD_DIG_W'(BCD_ADJ_TH)) ? din + BCD_DIG_W'(BCD_ADJ_ADD) : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-and-add-3 binary-to-BCD converter, one bit per clock
// Optional leading-zero blanking output enabled by defining BIN2BCD_BLANK_EN.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int BIN_W = 8,
  parameter int DIG_N = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [BIN_W-1:0]           bin,
  output logic                       busy,
  output logic                       done,
  output logic [BCD_DIG_W*DIG_N-1:0] bcd,
  output logic                       ovf
`ifdef BIN2BCD_BLANK_EN
  ,
  output logic [DIG_N-1:0]           blank_n
`endif
);

  localparam int ACC_W = BCD_DIG_W * DIG_N;
  localparam int CNT_W = $clog2(BIN_W + 1);

  state_t             state, state_nxt;
  logic               accept;
  logic               done_set;
  logic [BIN_W-1:0]   sreg;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   adj;
  logic               ovf_acc;
  logic [CNT_W-1:0]   cnt;

  for (genvar g = 0; g < DIG_N; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (acc[g*BCD_DIG_W +: BCD_DIG_W]),
      .dout (adj[g*BCD_DIG_W +: BCD_DIG_W])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // DONE can accept a new start directly, giving one conversion per BIN_W+1 cycles
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    done_set  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt == CNT_W'(1)) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done_set = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = ST_SHIFT;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg    <= '0;
      acc     <= '0;
      ovf_acc <= 1'b0;
      cnt     <= '0;
      bcd     <= '0;
      ovf     <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= done_set;
      if (done_set) begin
        bcd <= acc;
        ovf <= ovf_acc;
      end
      if (accept) begin
        sreg    <= bin;
        acc     <= '0;
        ovf_acc <= 1'b0;
        cnt     <= CNT_W'(BIN_W);
      end else if (state == ST_SHIFT) begin
        // bit leaving the top digit is lost from bcd but remembered as overflow
        acc     <= {adj[ACC_W-2:0], sreg[BIN_W-1]};
        ovf_acc <= ovf_acc | adj[ACC_W-1];
        sreg    <= sreg << 1;
        cnt     <= cnt - CNT_W'(1);
      end
    end
  end

`ifdef BIN2BCD_BLANK_EN
  logic [DIG_N-1:0] blank_nxt;
  logic             any_nz;

  always_comb begin
    blank_nxt = '0;
    any_nz    = 1'b0;
    for (int k = DIG_N - 1; k >= 1; k--) begin
      any_nz       = any_nz | (acc[k*BCD_DIG_W +: BCD_DIG_W] != '0);
      blank_nxt[k] = any_nz;
    end
    blank_nxt[0] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        blank_n <= DIG_N'(1);
    else if (done_set) blank_n <= blank_nxt;
  end
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - directed self-checking bench for bin2bcd_seq (8-bit and 10-bit instances)
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        start8, start10;
  logic [7:0]  bin8;
  logic [9:0]  bin10;
  logic        busy8, done8, ovf8;
  logic        busy10, done10, ovf10;
  logic [11:0] bcd8, bcd10;
`ifdef BIN2BCD_BLANK_EN
  logic [2:0]  blank8, blank10;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  bin2bcd_seq #(.BIN_W(8), .DIG_N(3)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .bin   (bin8),
    .busy  (busy8),
    .done  (done8),
    .bcd   (bcd8),
    .ovf   (ovf8)
`ifdef BIN2BCD_BLANK_EN
    ,
    .blank_n (blank8)
`endif
  );

  bin2bcd_seq #(.BIN_W(10), .DIG_N(3)) u_dut10 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start10),
    .bin   (bin10),
    .busy  (busy10),
    .done  (done10),
    .bcd   (bcd10),
    .ovf   (ovf10)
`ifdef BIN2BCD_BLANK_EN
    ,
    .blank_n (blank10)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // lat = number of falling edges from the start request until done is seen
  task automatic conv8(input logic [7:0] v, output logic [11:0] r, output logic o, output int lat);
    @(negedge clk);
    start8 = 1'b1;
    bin8   = v;
    @(negedge clk);
    start8 = 1'b0;
    lat    = 1;
    while (done8 !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    r = bcd8;
    o = ovf8;
  endtask

  task automatic conv10(input logic [9:0] v, output logic [11:0] r, output logic o, output int lat);
    @(negedge clk);
    start10 = 1'b1;
    bin10   = v;
    @(negedge clk);
    start10 = 1'b0;
    lat     = 1;
    while (done10 !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    r = bcd10;
    o = ovf10;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({busy8, done8, ovf8, bcd8} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset8 got busy=%b done=%b ovf=%b bcd=%h want all 0", busy8, done8, ovf8, bcd8);
    end
    n_cmp++;
    if ({busy10, done10, ovf10, bcd10} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset10 got busy=%b done=%b ovf=%b bcd=%h want all 0", busy10, done10, ovf10, bcd10);
    end
`ifdef BIN2BCD_BLANK_EN
    n_cmp++;
    if (blank8 !== 3'b001) begin
      n_fail++;
      $display("FAIL reset_blank got %b want 001", blank8);
    end
`endif
  endtask

  task automatic test_basic();
    logic [7:0]  vin  [4] = '{8'd255, 8'd128, 8'd1, 8'd99};
    logic [11:0] vexp [4] = '{12'h255, 12'h128, 12'h001, 12'h099};
    logic [11:0] r;
    logic        o;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      conv8(vin[i], r, o, lat);
      n_cmp++;
      if (lat !== 10) begin
        n_fail++;
        $display("FAIL basic_latency v=%0d got %0d want 10", vin[i], lat);
      end
      n_cmp++;
      if (r !== vexp[i] || o !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_bcd v=%0d got %h ovf=%b want %h ovf=0", vin[i], r, o, vexp[i]);
      end
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bcd8 !== 12'h099) begin
      n_fail++;
      $display("FAIL basic_hold got %h want 099", bcd8);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    start8 = 1'b1;
    bin8   = 8'd0;
    @(negedge clk);
    bin8 = 8'd9;
    lat  = 1;
    while (done8 !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    start8 = 1'b0;
    n_cmp++;
    if (lat !== 10 || bcd8 !== 12'h000 || ovf8 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_first got lat=%0d bcd=%h ovf=%b want lat=10 bcd=000 ovf=0", lat, bcd8, ovf8);
    end
    @(negedge clk);
    lat++;
    n_cmp++;
    if (done8 !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse got done=%b want 0", done8);
    end
    while (done8 !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (lat !== 19 || bcd8 !== 12'h009 || ovf8 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second got lat=%0d bcd=%h ovf=%b want lat=19 bcd=009 ovf=0", lat, bcd8, ovf8);
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    @(negedge clk);
    start8 = 1'b1;
    bin8   = 8'd200;
    @(negedge clk);
    start8 = 1'b0;
    lat    = 1;
    n_cmp++;
    if (busy8 !== 1'b1 || bcd8 !== 12'h009) begin
      n_fail++;
      $display("FAIL busy_hold got busy=%b bcd=%h want busy=1 bcd=009", busy8, bcd8);
    end
    @(negedge clk);
    lat    = 2;
    start8 = 1'b1;
    bin8   = 8'd55;
    @(negedge clk);
    lat    = 3;
    start8 = 1'b0;
    while (done8 !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (lat !== 10 || bcd8 !== 12'h200) begin
      n_fail++;
      $display("FAIL start_ignored got lat=%0d bcd=%h want lat=10 bcd=200", lat, bcd8);
    end
  endtask

  task automatic test_ovf();
    logic [11:0] r;
    logic        o;
    int          lat;
    conv10(10'd1023, r, o, lat);
    n_cmp++;
    if (lat !== 12 || r !== 12'h023 || o !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_1023 got lat=%0d bcd=%h ovf=%b want lat=12 bcd=023 ovf=1", lat, r, o);
    end
    conv10(10'd999, r, o, lat);
    n_cmp++;
    if (lat !== 12 || r !== 12'h999 || o !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_999 got lat=%0d bcd=%h ovf=%b want lat=12 bcd=999 ovf=0", lat, r, o);
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] r;
    logic        o;
    int          lat;
    int          seen;
    @(negedge clk);
    start8 = 1'b1;
    bin8   = 8'd77;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy8 !== 1'b0 || bcd8 !== 12'h000 || done8 !== 1'b0 || ovf8 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid got busy=%b bcd=%h done=%b ovf=%b want all 0", busy8, bcd8, done8, ovf8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done8 === 1'b1) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL reset_no_done got %0d done pulses want 0", seen);
    end
    conv8(8'd42, r, o, lat);
    n_cmp++;
    if (lat !== 10 || r !== 12'h042 || o !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset got lat=%0d bcd=%h ovf=%b want lat=10 bcd=042 ovf=0", lat, r, o);
    end
  endtask

`ifdef BIN2BCD_BLANK_EN
  task automatic test_blank();
    logic [11:0] r;
    logic        o;
    int          lat;
    int          d0, d1, d2;
    logic [11:0] eb;
    logic [2:0]  ebl;
    conv8(8'd7, r, o, lat);
    n_cmp++;
    if (blank8 !== 3'b001) begin
      n_fail++;
      $display("FAIL blank_7 got %b want 001", blank8);
    end
    conv8(8'd100, r, o, lat);
    n_cmp++;
    if (blank8 !== 3'b111) begin
      n_fail++;
      $display("FAIL blank_100 got %b want 111", blank8);
    end
    for (int v = 0; v < 256; v++) begin
      conv8(v[7:0], r, o, lat);
      d0  = v % 10;
      d1  = (v / 10) % 10;
      d2  = v / 100;
      eb  = {d2[3:0], d1[3:0], d0[3:0]};
      ebl = {d2 != 0, (d2 != 0) || (d1 != 0), 1'b1};
      n_cmp++;
      if (r !== eb || o !== 1'b0 || blank8 !== ebl || lat !== 10) begin
        n_fail++;
        $display("FAIL exhaustive v=%0d got bcd=%h ovf=%b blank=%b lat=%0d want bcd=%h ovf=0 blank=%b lat=10",
                 v, r, o, blank8, lat, eb, ebl);
      end
    end
  endtask
`endif

  initial begin
    rst_n   = 1'b0;
    start8  = 1'b0;
    start10 = 1'b0;
    bin8    = '0;
    bin10   = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_start_ignored();
    test_ovf();
    test_reset_mid();
`ifdef BIN2BCD_BLANK_EN
    test_blank();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
